// File: rtl/data_memory_if.sv
// Memory-port bundle between the data cache (master) and the main-memory responder (slave).
interface data_memory_if;
    logic [31:0] mem_addr;
    logic [7:0]  mem_data_in  [0:3];
    logic        mem_write_en;
    logic [7:0]  mem_data_out [0:3];
    logic        ready;

    modport master (
        output mem_addr,
        output mem_data_in,
        output mem_write_en,
        input  mem_data_out,
        input  ready
    );

    modport slave (
        input  mem_addr,
        input  mem_data_in,
        input  mem_write_en,
        output mem_data_out,
        output ready
    );
endinterface

// File: rtl/data_memory.sv
// Word-organised main memory with a fixed access latency for reads and write commits.
// Reads track the presented word index; writes are latched and committed LATENCY edges later.
module data_memory #(
    parameter int unsigned ADDR_BITS = 16,
    parameter int unsigned LATENCY   = 4
) (
    input  logic          clk,
    input  logic          rst,
    data_memory_if.slave  mem
);

    localparam int unsigned IdxBits = ADDR_BITS - 2;
    localparam int unsigned Depth   = 1 << IdxBits;
    localparam logic [3:0]  CntLast = 4'(LATENCY - 1);

    typedef enum logic [0:0] {
        StIdle,
        StWriteBusy
    } state_e;

    state_e               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [IdxBits-1:0]   rd_idx_q, rd_idx_d;
    logic [IdxBits-1:0]   wr_idx_q, wr_idx_d;
    logic [31:0]          wr_data_q, wr_data_d;
    logic [31:0]          data_q, data_d;
    logic                 ready_q, ready_d;
    logic                 commit;

    logic [31:0]          mem_q [Depth];

    logic [IdxBits-1:0]   addr_idx;
    logic [31:0]          wr_word;
    logic                 unused_addr_bits;

    // Bits outside the word index are ignored, so aliases map to the same word.
    assign addr_idx         = mem.mem_addr[ADDR_BITS-1:2];
    assign unused_addr_bits = ^{mem.mem_addr[31:ADDR_BITS], mem.mem_addr[1:0]};

    // Byte k of the bus occupies word bits [8k+7:8k].
    assign wr_word = {mem.mem_data_in[3], mem.mem_data_in[2],
                      mem.mem_data_in[1], mem.mem_data_in[0]};

    // Unpack the registered read word back onto the byte-array bus.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            mem.mem_data_out[k] = data_q[8*k +: 8];
        end
    end

    assign mem.ready = ready_q;

    // Next-state: read tracking in idle, latency countdown to commit while write-busy.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_idx_d  = rd_idx_q;
        wr_idx_d  = wr_idx_q;
        wr_data_d = wr_data_q;
        data_d    = data_q;
        ready_d   = ready_q;
        commit    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (mem.mem_write_en) begin
                    // A write pre-empts any read in flight.
                    wr_idx_d  = addr_idx;
                    wr_data_d = wr_word;
                    cnt_d     = '0;
                    ready_d   = 1'b0;
                    state_d   = StWriteBusy;
                end else if (addr_idx != rd_idx_q) begin
                    rd_idx_d = addr_idx;
                    cnt_d    = '0;
                    ready_d  = 1'b0;
                end else if (!ready_q) begin
                    if (cnt_q == CntLast) begin
                        data_d  = mem_q[rd_idx_q];
                        ready_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            StWriteBusy: begin
                if (cnt_q == CntLast) begin
                    // Restart the read at the current address so it sees post-write data.
                    commit   = 1'b1;
                    state_d  = StIdle;
                    cnt_d    = '0;
                    ready_d  = 1'b0;
                    rd_idx_d = addr_idx;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Control and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            rd_idx_q  <= '0;
            wr_idx_q  <= '0;
            wr_data_q <= '0;
            data_q    <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_idx_q  <= rd_idx_d;
            wr_idx_q  <= wr_idx_d;
            wr_data_q <= wr_data_d;
            data_q    <= data_d;
            ready_q   <= ready_d;
        end
    end

    // Storage: cleared on reset, written only on the commit edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (commit) begin
            mem_q[wr_idx_q] <= wr_data_q;
        end
    end

endmodule
